// File: rtl/sd_spi_card_emu_if.sv
// SPI link between an SD host and the emulated card.
// master: host side (drives clock, data out and chip select).
// slave : card side (drives spi_miso).
interface sd_spi_card_emu_if;
    logic spi_clk;
    logic spi_mosi;
    logic spi_cs;
    logic spi_miso;

    modport master (output spi_clk, output spi_mosi, output spi_cs, input spi_miso);
    modport slave  (input spi_clk, input spi_mosi, input spi_cs, output spi_miso);
endinterface

// File: rtl/sd_spi_card_emu.sv
// SPI-mode SD card responder backed by an NBLOCKS x 512-byte block store.
// Handles CMD0, CMD8, CMD55/ACMD41, CMD58, CMD17 and CMD24 with block addressing.
// Optional macro SD_EMU_CRC7_EN: check the CRC7 of each received command;
// when undefined the CRC byte is consumed but ignored.
module sd_spi_card_emu #(
    parameter int NBLOCKS    = 4,
    parameter int NCR_BYTES  = 1,
    parameter int BUSY_BYTES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    sd_spi_card_emu_if.slave    spi,
    output logic                card_idle,
    output logic [5:0]          last_cmd,
    output logic                blk_wr_done
);
    localparam int BW    = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;
    localparam int AW    = $clog2(NBLOCKS * 512);
    localparam int DEPTH = NBLOCKS * 512;

    typedef enum logic [3:0] {
        S_WAIT  = 4'd0,  S_CMD   = 4'd1,  S_NCR   = 4'd2,  S_R1    = 4'd3,
        S_TAIL  = 4'd4,  S_RTOK  = 4'd5,  S_RDATA = 4'd6,  S_RCRC  = 4'd7,
        S_WTOK  = 4'd8,  S_WDATA = 4'd9,  S_WCRC  = 4'd10, S_WRESP = 4'd11,
        S_BUSY  = 4'd12
    } state_t;

    logic [1:0]    sclk_sync_r, mosi_sync_r, cs_sync_r;
    logic          sclk_prev_r;
    logic          cs_high_s, rise_s, fall_s, byte_stb_s;
    logic [2:0]    bit_cnt_r;
    logic [6:0]    rx_r;
    logic [7:0]    rx_byte_s, tx_r, tx_next_s;
    state_t        st_r, st_next_s, follow_s, post_r, dec_post_s;
    logic          adv_s;
    logic [8:0]    cnt_r, cnt_next_s, rd_off_s;
    logic [5:0]    cmd_idx_r, last_cmd_r;
    logic [31:0]   arg_r, tail_r, dec_tail_s;
    logic [BW-1:0] blk_r;
    logic [7:0]    r1_r, dec_r1_s, r1_illegal_s;
    logic          app_r, a41_r, card_idle_r, wr_done_r;
    logic          dec_stb_s, dec_app_s, dec_a41_s, dec_idle_s, dec_accept_s, crc_bad_s;
    logic          wr_en_s, wr_done_s;
    logic [7:0]    mem_r [DEPTH];
    logic [7:0]    rd_data_r;
    logic [AW-1:0] rd_addr_s, wr_addr_s;

`ifdef SD_EMU_CRC7_EN
    // CRC7 (x^7 + x^3 + 1) over the command byte and the 32-bit argument.
    function automatic logic [6:0] crc7_f(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction
    assign crc_bad_s = (rx_byte_s != {crc7_f({2'b01, cmd_idx_r, arg_r}), 1'b1});
`else
    assign crc_bad_s = 1'b0;
`endif

    assign cs_high_s    = cs_sync_r[1];
    assign rise_s       = sclk_sync_r[1] & ~sclk_prev_r & ~cs_high_s;
    assign fall_s       = ~sclk_sync_r[1] & sclk_prev_r & ~cs_high_s;
    assign byte_stb_s   = rise_s & (bit_cnt_r == 3'd7);
    assign rx_byte_s    = {rx_r, mosi_sync_r[1]};
    assign dec_stb_s    = byte_stb_s & (st_r == S_CMD) & (cnt_r == 9'd4);
    assign r1_illegal_s = {5'b00000, 1'b1, 1'b0, card_idle_r};
    assign rd_off_s     = (st_r == S_RDATA) ? (cnt_r + 9'd1) : 9'd0;
    assign rd_addr_s    = AW'({blk_r, rd_off_s});
    assign wr_addr_s    = AW'({blk_r, cnt_r});

    assign spi.spi_miso = tx_r[7];
    assign card_idle    = card_idle_r;
    assign last_cmd     = last_cmd_r;
    assign blk_wr_done  = wr_done_r;

    // Bring the asynchronous SPI pins into the clk domain and keep the previous clock level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= 2'b00;
            mosi_sync_r <= 2'b00;
            cs_sync_r   <= 2'b11;
            sclk_prev_r <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[0], spi.spi_clk};
            mosi_sync_r <= {mosi_sync_r[0], spi.spi_mosi};
            cs_sync_r   <= {cs_sync_r[0], spi.spi_cs};
            sclk_prev_r <= sclk_sync_r[1];
        end
    end

    // Bit-level shifter: sample mosi on rising edges, shift miso on falling edges within a byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 3'd0;
            rx_r      <= 7'd0;
            tx_r      <= 8'hFF;
        end else if (cs_high_s) begin
            bit_cnt_r <= 3'd0;
            tx_r      <= 8'hFF;
        end else begin
            if (rise_s) begin
                rx_r      <= rx_byte_s[6:0];
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            // The falling edge right after the byte strobe (bit_cnt 0) must not shift the fresh byte.
            if (byte_stb_s) begin
                tx_r <= tx_next_s;
            end else if (fall_s && (bit_cnt_r != 3'd0)) begin
                tx_r <= {tx_r[6:0], 1'b1};
            end
        end
    end

    // FSM state and per-state byte counter; deselect always returns to idle wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r  <= S_WAIT;
            cnt_r <= 9'd0;
        end else if (cs_high_s) begin
            st_r  <= S_WAIT;
            cnt_r <= 9'd0;
        end else if (byte_stb_s) begin
            st_r  <= st_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    // Next state: each state ends on a byte-count or received-byte condition.
    always_comb begin
        adv_s    = 1'b0;
        follow_s = S_WAIT;
        case (st_r)
            S_WAIT:  begin adv_s = (rx_byte_s[7:6] == 2'b01);       follow_s = S_CMD;   end
            S_CMD:   begin adv_s = (cnt_r == 9'd4);                  follow_s = S_NCR;   end
            S_NCR:   begin adv_s = (cnt_r == 9'(NCR_BYTES - 1));     follow_s = S_R1;    end
            S_R1:    begin adv_s = 1'b1;                             follow_s = post_r;  end
            S_TAIL:  begin adv_s = (cnt_r == 9'd3);                  follow_s = S_WAIT;  end
            S_RTOK:  begin adv_s = (cnt_r == 9'd1);                  follow_s = S_RDATA; end
            S_RDATA: begin adv_s = (cnt_r == 9'd511);                follow_s = S_RCRC;  end
            S_RCRC:  begin adv_s = (cnt_r == 9'd1);                  follow_s = S_WAIT;  end
            S_WTOK:  begin
                adv_s    = (rx_byte_s != 8'hFF);
                follow_s = (rx_byte_s == 8'hFE) ? S_WDATA : S_WAIT;
            end
            S_WDATA: begin adv_s = (cnt_r == 9'd511);                follow_s = S_WCRC;  end
            S_WCRC:  begin adv_s = (cnt_r == 9'd1);                  follow_s = S_WRESP; end
            S_WRESP: begin adv_s = 1'b1;                             follow_s = S_BUSY;  end
            S_BUSY:  begin adv_s = (cnt_r == 9'(BUSY_BYTES - 1));    follow_s = S_WAIT;  end
            default: begin adv_s = 1'b1;                             follow_s = S_WAIT;  end
        endcase
        if (adv_s) begin
            st_next_s  = follow_s;
            cnt_next_s = 9'd0;
        end else begin
            st_next_s  = st_r;
            cnt_next_s = cnt_r + 9'd1;
        end
    end

    // Outputs: the byte to send in the next byte slot, store write enable and commit pulse.
    always_comb begin
        tx_next_s = 8'hFF;
        case (st_next_s)
            S_R1:    tx_next_s = r1_r;
            S_TAIL: begin
                case (cnt_next_s[1:0])
                    2'd0:    tx_next_s = tail_r[31:24];
                    2'd1:    tx_next_s = tail_r[23:16];
                    2'd2:    tx_next_s = tail_r[15:8];
                    default: tx_next_s = tail_r[7:0];
                endcase
            end
            S_RTOK:  tx_next_s = (cnt_next_s == 9'd0) ? 8'hFF : 8'hFE;
            S_RDATA: tx_next_s = rd_data_r;
            S_WRESP: tx_next_s = 8'h05;
            S_BUSY:  tx_next_s = 8'h00;
            default: tx_next_s = 8'hFF;
        endcase
        wr_en_s   = byte_stb_s & (st_r == S_WDATA);
        wr_done_s = byte_stb_s & (st_r == S_WCRC) & (st_next_s == S_WRESP);
    end

    // Command decode, evaluated when the CRC byte arrives.
    always_comb begin
        dec_r1_s     = r1_illegal_s;
        dec_post_s   = S_WAIT;
        dec_tail_s   = tail_r;
        dec_idle_s   = card_idle_r;
        dec_app_s    = 1'b0;
        dec_a41_s    = a41_r;
        dec_accept_s = 1'b1;
        if (crc_bad_s) begin
            dec_r1_s     = {4'b0000, 1'b1, 2'b00, card_idle_r};
            dec_app_s    = app_r;
            dec_accept_s = 1'b0;
        end else begin
            case (cmd_idx_r)
                6'd0: begin
                    dec_idle_s = 1'b1;
                    dec_a41_s  = 1'b0;
                    dec_r1_s   = 8'h01;
                end
                6'd8: begin
                    dec_r1_s   = {7'b0000000, card_idle_r};
                    dec_post_s = S_TAIL;
                    dec_tail_s = {8'h00, 8'h00, 8'h01, arg_r[7:0]};
                end
                6'd58: begin
                    dec_r1_s   = {7'b0000000, card_idle_r};
                    dec_post_s = S_TAIL;
                    dec_tail_s = 32'hC0FF_8000;
                end
                6'd55: begin
                    dec_r1_s  = {7'b0000000, card_idle_r};
                    dec_app_s = 1'b1;
                end
                6'd41: begin
                    if (!app_r) begin
                        dec_r1_s = r1_illegal_s;
                    end else if (card_idle_r && !a41_r) begin
                        dec_a41_s = 1'b1;
                        dec_r1_s  = 8'h01;
                    end else begin
                        dec_idle_s = 1'b0;
                        dec_r1_s   = 8'h00;
                    end
                end
                6'd17, 6'd24: begin
                    if (card_idle_r) begin
                        dec_r1_s = r1_illegal_s;
                    end else if (arg_r >= 32'(NBLOCKS)) begin
                        dec_r1_s = 8'h40;
                    end else begin
                        dec_r1_s   = 8'h00;
                        dec_post_s = (cmd_idx_r == 6'd17) ? S_RTOK : S_WTOK;
                    end
                end
                default: dec_r1_s = r1_illegal_s;
            endcase
        end
    end

    // Command capture, card state flags and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_idx_r   <= 6'd0;
            arg_r       <= 32'd0;
            blk_r       <= '0;
            r1_r        <= 8'hFF;
            post_r      <= S_WAIT;
            tail_r      <= 32'd0;
            app_r       <= 1'b0;
            a41_r       <= 1'b0;
            card_idle_r <= 1'b1;
            last_cmd_r  <= 6'd0;
            wr_done_r   <= 1'b0;
        end else begin
            wr_done_r <= wr_done_s;
            if (byte_stb_s && (st_r == S_WAIT) && (rx_byte_s[7:6] == 2'b01)) begin
                cmd_idx_r <= rx_byte_s[5:0];
            end
            if (byte_stb_s && (st_r == S_CMD) && (cnt_r < 9'd4)) begin
                arg_r <= {arg_r[23:0], rx_byte_s};
            end
            if (dec_stb_s) begin
                r1_r        <= dec_r1_s;
                post_r      <= dec_post_s;
                tail_r      <= dec_tail_s;
                app_r       <= dec_app_s;
                a41_r       <= dec_a41_s;
                card_idle_r <= dec_idle_s;
                blk_r       <= arg_r[BW-1:0];
                if (dec_accept_s) begin
                    last_cmd_r <= cmd_idx_r;
                end
            end
        end
    end

    // Block store: write on the data-byte strobe, read one byte ahead of the transmit slot.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_addr_s] <= rx_byte_s;
        end
        rd_data_r <= mem_r[rd_addr_s];
    end
endmodule

// File: tb/tb_sd_spi_card_emu.sv
// Directed bench for sd_spi_card_emu: drives SPI mode 0 as the host and
// compares every response byte with hand-derived values.
module tb_sd_spi_card_emu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       card_idle;
    logic [5:0] last_cmd;
    logic       blk_wr_done;
    int         checks = 0;
    int         errors = 0;
    int         wr_pulses = 0;

    sd_spi_card_emu_if spi_if ();

    sd_spi_card_emu #(.NBLOCKS(4), .NCR_BYTES(1), .BUSY_BYTES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (spi_if),
        .card_idle   (card_idle),
        .last_cmd    (last_cmd),
        .blk_wr_done (blk_wr_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && blk_wr_done) wr_pulses <= wr_pulses + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [6:0] c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
            else             c = {c[5:0], 1'b0};
        end
        return c;
    endfunction

    // One byte exchange: mosi set at the falling edge, miso read late in the high phase.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_if.spi_mosi = tx[i];
            #20;
            spi_if.spi_clk = 1'b1;
            #20;
            rx[i] = spi_if.spi_miso;
            spi_if.spi_clk = 1'b0;
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] r;
        xfer(8'hFF, r);
        check_val(tag, {24'd0, r}, {24'd0, exp});
    endtask

    task automatic cs_low();
        spi_if.spi_cs = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        spi_if.spi_cs = 1'b1;
        #100;
    endtask

    // Select the card, send a 6-byte command, check the NCR filler and R1.
    task automatic cmd_r1(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input logic bad_crc, input logic [7:0] exp_r1);
        logic [7:0] r;
        logic [7:0] crc;
        crc = bad_crc ? 8'h00 : {ref_crc7({2'b01, idx, arg}), 1'b1};
        cs_low();
        xfer({2'b01, idx}, r);
        xfer(arg[31:24], r);
        xfer(arg[23:16], r);
        xfer(arg[15:8], r);
        xfer(arg[7:0], r);
        xfer(crc, r);
        expect_byte({tag, "_ncr"}, 8'hFF);
        expect_byte({tag, "_r1"}, exp_r1);
    endtask

    task automatic read_block(input string tag, input int split);
        logic [7:0] exp;
        logic [7:0] r;
        expect_byte({tag, "_pre"}, 8'hFF);
        expect_byte({tag, "_tok"}, 8'hFE);
        for (int i = 0; i < 512; i++) begin
            exp = (i < split) ? (8'(i) ^ 8'h5A) : 8'(i);
            xfer(8'hFF, r);
            check_val($sformatf("%s_d%0d", tag, i), {24'd0, r}, {24'd0, exp});
        end
        expect_byte({tag, "_crc0"}, 8'hFF);
        expect_byte({tag, "_crc1"}, 8'hFF);
        expect_byte({tag, "_idle"}, 8'hFF);
    endtask

    initial begin
        logic [7:0] r;
        spi_if.spi_clk  = 1'b0;
        spi_if.spi_mosi = 1'b1;
        spi_if.spi_cs   = 1'b1;
        #40;
        rst_n = 1'b1;
        #40;
        check_val("rst_miso", {31'd0, spi_if.spi_miso}, 32'd1);
        check_val("rst_idle", {31'd0, card_idle}, 32'd1);
        check_val("rst_last_cmd", {26'd0, last_cmd}, 32'd0);
        check_val("rst_wr_done", {31'd0, blk_wr_done}, 32'd0);

`ifdef SD_EMU_CRC7_EN
        cmd_r1("cmd0_badcrc", 6'd0, 32'd0, 1'b1, 8'h09);
        cs_high();
`endif
        cmd_r1("cmd0", 6'd0, 32'd0, 1'b0, 8'h01);
        check_val("cmd0_idle", {31'd0, card_idle}, 32'd1);
        cs_high();

        cmd_r1("cmd8", 6'd8, 32'h0000_01AA, 1'b0, 8'h01);
        expect_byte("cmd8_t0", 8'h00);
        expect_byte("cmd8_t1", 8'h00);
        expect_byte("cmd8_t2", 8'h01);
        expect_byte("cmd8_t3", 8'hAA);
        expect_byte("cmd8_end", 8'hFF);
        check_val("cmd8_last", {26'd0, last_cmd}, 32'd8);
        cs_high();

        cmd_r1("cmd17_idle", 6'd17, 32'd0, 1'b0, 8'h05);
        expect_byte("cmd17_idle_end", 8'hFF);
        cs_high();

        cmd_r1("cmd55_a", 6'd55, 32'd0, 1'b0, 8'h01);
        cs_high();
        cmd_r1("acmd41_a", 6'd41, 32'h4000_0000, 1'b0, 8'h01);
        cs_high();
        cmd_r1("cmd55_b", 6'd55, 32'd0, 1'b0, 8'h01);
        cs_high();
        cmd_r1("acmd41_b", 6'd41, 32'h4000_0000, 1'b0, 8'h00);
        check_val("acmd41_idle", {31'd0, card_idle}, 32'd0);
        cs_high();

        cmd_r1("cmd58", 6'd58, 32'd0, 1'b0, 8'h00);
        expect_byte("ocr0", 8'hC0);
        expect_byte("ocr1", 8'hFF);
        expect_byte("ocr2", 8'h80);
        expect_byte("ocr3", 8'h00);
        check_val("cmd58_last", {26'd0, last_cmd}, 32'd58);
        cs_high();

        // Full block write of i & 0xFF to block 2.
        cmd_r1("cmd24", 6'd24, 32'd2, 1'b0, 8'h00);
        xfer(8'hFF, r);
        check_val("cmd24_wtok", {24'd0, r}, 32'h0000_00FF);
        xfer(8'hFE, r);
        for (int i = 0; i < 512; i++) xfer(8'(i), r);
        xfer(8'hFF, r);
        xfer(8'hFF, r);
        expect_byte("cmd24_resp", 8'h05);
        expect_byte("cmd24_busy0", 8'h00);
        expect_byte("cmd24_busy1", 8'h00);
        expect_byte("cmd24_end", 8'hFF);
        check_val("cmd24_pulses", wr_pulses, 32'd1);
        check_val("cmd24_last", {26'd0, last_cmd}, 32'd24);
        cs_high();

        cmd_r1("cmd17_b2", 6'd17, 32'd2, 1'b0, 8'h00);
        read_block("rd_full", 0);
        cs_high();

        cmd_r1("cmd17_oor", 6'd17, 32'd4, 1'b0, 8'h40);
        expect_byte("oor_b0", 8'hFF);
        expect_byte("oor_b1", 8'hFF);
        cs_high();

        // Partial write aborted by deselect after 100 data bytes.
        cmd_r1("cmd24_part", 6'd24, 32'd2, 1'b0, 8'h00);
        xfer(8'hFE, r);
        for (int i = 0; i < 100; i++) xfer(8'(i) ^ 8'h5A, r);
        cs_high();
        check_val("part_pulses", wr_pulses, 32'd1);
        check_val("part_idle", {31'd0, card_idle}, 32'd0);

        cmd_r1("cmd17_part", 6'd17, 32'd2, 1'b0, 8'h00);
        read_block("rd_part", 100);
        cs_high();

        cmd_r1("cmd0_again", 6'd0, 32'd0, 1'b0, 8'h01);
        check_val("cmd0_again_idle", {31'd0, card_idle}, 32'd1);
        check_val("cmd0_again_last", {26'd0, last_cmd}, 32'd0);
        cs_high();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
